// File: rtl/buffer_rx.sv
// Receive decoder for the 2-bit buffer symbol stream; assembles MSB-first words.
// Optional even-parity trailer symbol enabled by BUFFER_RX_PARITY_EN.
module buffer_rx #(
    parameter int DATA_W  = 8,
    parameter int MAX_GAP = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        in,
    output logic [DATA_W-1:0] word,
    output logic              valid,
    output logic              err,
    output logic [1:0]        err_code,
    output logic              busy,
    output logic [7:0]        frame_cnt
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam int GW = $clog2(MAX_GAP + 1);

    localparam logic [1:0] SYM_IDLE = 2'b00;
    localparam logic [1:0] SYM_ILL  = 2'b01;

    localparam logic [1:0] E_NONE = 2'b00;
    localparam logic [1:0] E_ILL  = 2'b01;
    localparam logic [1:0] E_GAP  = 2'b10;
`ifdef BUFFER_RX_PARITY_EN
    localparam logic [1:0] E_PAR  = 2'b11;
`endif

`ifdef BUFFER_RX_PARITY_EN
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RECV = 2'b01,
        PAR  = 2'b10
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RECV = 2'b01
    } state_t;
`endif

    state_t            state, state_n;
    logic [DATA_W-1:0] sr, sr_n;
    logic [CW-1:0]     bitcnt, bitcnt_n;
    logic [GW-1:0]     gap, gap_n;
    logic [DATA_W-1:0] word_n;
    logic              valid_n;
    logic              err_n;
    logic [1:0]        code_n;
    logic [7:0]        cnt_n;
    logic [DATA_W-1:0] shifted;

    assign shifted = {sr[DATA_W-2:0], in[0]};
    assign busy    = (state != IDLE);

    always_comb begin
        state_n  = state;
        sr_n     = sr;
        bitcnt_n = bitcnt;
        gap_n    = gap;
        word_n   = word;
        valid_n  = 1'b0;
        err_n    = 1'b0;
        code_n   = E_NONE;
        cnt_n    = frame_cnt;

        unique case (state)
            IDLE: begin
                if (in == SYM_ILL) begin
                    err_n  = 1'b1;
                    code_n = E_ILL;
                end else if (in[1]) begin
                    sr_n     = {{(DATA_W-1){1'b0}}, in[0]};
                    bitcnt_n = CW'(1);
                    gap_n    = '0;
                    state_n  = RECV;
                end
            end
            RECV: begin
                if (in[1]) begin
                    sr_n     = shifted;
                    bitcnt_n = bitcnt + CW'(1);
                    gap_n    = '0;
                    if (bitcnt_n == CW'(DATA_W)) begin
`ifdef BUFFER_RX_PARITY_EN
                        state_n = PAR;
`else
                        word_n   = shifted;
                        valid_n  = 1'b1;
                        cnt_n    = frame_cnt + 8'd1;
                        bitcnt_n = '0;
                        state_n  = IDLE;
`endif
                    end
                end
            end
`ifdef BUFFER_RX_PARITY_EN
            PAR: begin
                if (in[1]) begin
                    // even parity: data bits xor parity bit must be zero
                    if ((^sr ^ in[0]) == 1'b0) begin
                        word_n  = sr;
                        valid_n = 1'b1;
                        cnt_n   = frame_cnt + 8'd1;
                    end else begin
                        err_n  = 1'b1;
                        code_n = E_PAR;
                    end
                    bitcnt_n = '0;
                    gap_n    = '0;
                    state_n  = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase

        // gap and illegal handling shared by every in-frame state
        if (state != IDLE && !in[1]) begin
            if (in == SYM_IDLE) begin
                gap_n = gap + GW'(1);
                if (gap_n == GW'(MAX_GAP)) begin
                    err_n  = 1'b1;
                    code_n = E_GAP;
                end
            end else begin
                err_n  = 1'b1;
                code_n = E_ILL;
            end
            if (err_n) begin
                sr_n     = '0;
                bitcnt_n = '0;
                gap_n    = '0;
                state_n  = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sr        <= '0;
            bitcnt    <= '0;
            gap       <= '0;
            word      <= '0;
            valid     <= 1'b0;
            err       <= 1'b0;
            err_code  <= E_NONE;
            frame_cnt <= 8'd0;
        end else begin
            state     <= state_n;
            sr        <= sr_n;
            bitcnt    <= bitcnt_n;
            gap       <= gap_n;
            word      <= word_n;
            valid     <= valid_n;
            err       <= err_n;
            err_code  <= code_n;
            frame_cnt <= cnt_n;
        end
    end

endmodule

// File: tb/tb_buffer_rx.sv
// Directed self-checking bench for buffer_rx (DATA_W=8, MAX_GAP=3).
// Define BUFFER_RX_PARITY_EN to also exercise the parity trailer.
module tb_buffer_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] in;
    logic [7:0] word;
    logic       valid;
    logic       err;
    logic [1:0] err_code;
    logic       busy;
    logic [7:0] frame_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    buffer_rx #(.DATA_W(8), .MAX_GAP(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in),
        .word      (word),
        .valid     (valid),
        .err       (err),
        .err_code  (err_code),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    task automatic step(input logic [1:0] s);
        in = s;
        @(posedge clk);
        #1;
    endtask

    int pulses;
    int errs;

    task automatic send_bits(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) begin
            step({1'b1, d[i]});
            pulses += int'(valid);
            errs   += int'(err);
        end
    endtask

    task automatic send_frame(input string tag, input logic [7:0] d);
        pulses = 0;
        errs   = 0;
        send_bits(d);
`ifdef BUFFER_RX_PARITY_EN
        step({1'b1, ^d});
        pulses += int'(valid);
        errs   += int'(err);
`endif
        check({tag, "_vld_last"}, valid, 1);
        check({tag, "_pulses"}, pulses, 1);
        check({tag, "_errs"}, errs, 0);
        check({tag, "_word"}, word, d);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        in    = 2'b00;
        step(2'b00);
        step(2'b00);
        check("rst_word", word, 0);
        check("rst_valid", valid, 0);
        check("rst_err", err, 0);
        check("rst_code", err_code, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", frame_cnt, 0);
        reset = 1'b0;
        step(2'b00);

        send_frame("a5", 8'hA5);
        check("a5_cnt", frame_cnt, 1);
        step(2'b00);
        check("a5_vld_drop", valid, 0);

        // same frame with two idles inside it
        pulses = 0;
        errs   = 0;
        step(2'b11); step(2'b10); step(2'b11);
        step(2'b00);
        check("gap1_busy", busy, 1);
        step(2'b00);
        check("gap2_err", err, 0);
        check("gap2_busy", busy, 1);
        step(2'b10); step(2'b10); step(2'b11); step(2'b10);
        pulses += int'(valid);
        step(2'b11);
        pulses += int'(valid);
`ifdef BUFFER_RX_PARITY_EN
        check("gapf_vld_pre", valid, 0);
        step(2'b10);
        pulses += int'(valid);
`endif
        check("gapf_valid", valid, 1);
        check("gapf_pulses", pulses, 1);
        check("gapf_word", word, 8'hA5);
        check("gapf_cnt", frame_cnt, 2);
        check("gapf_err", err, 0);

        // gap timeout
        step(2'b11); step(2'b11); step(2'b10);
        step(2'b00); step(2'b00);
        check("to_pre_err", err, 0);
        step(2'b00);
        check("to_err", err, 1);
        check("to_code", err_code, 2'b10);
        check("to_valid", valid, 0);
        check("to_busy", busy, 0);
        check("to_word", word, 8'hA5);
        step(2'b00);
        check("to_err_drop", err, 0);
        check("to_code_drop", err_code, 0);
        send_frame("3c", 8'h3C);
        check("3c_cnt", frame_cnt, 3);

        // illegal symbol in idle and mid-frame
        step(2'b01);
        check("ill_idle_err", err, 1);
        check("ill_idle_code", err_code, 2'b01);
        check("ill_idle_busy", busy, 0);
        step(2'b11); step(2'b10); step(2'b11); step(2'b11); step(2'b10);
        check("ill_mid_busy", busy, 1);
        step(2'b01);
        check("ill_mid_err", err, 1);
        check("ill_mid_code", err_code, 2'b01);
        check("ill_mid_busy0", busy, 0);
        check("ill_mid_valid", valid, 0);
        check("ill_mid_word", word, 8'h3C);
        check("ill_mid_cnt", frame_cnt, 3);

        // reset mid-frame, with a data symbol on the reset cycle
        step(2'b11); step(2'b10); step(2'b11); step(2'b10);
        reset = 1'b1;
        step(2'b11);
        check("mrst_valid", valid, 0);
        check("mrst_err", err, 0);
        check("mrst_word", word, 0);
        check("mrst_busy", busy, 0);
        check("mrst_cnt", frame_cnt, 0);
        reset = 1'b0;

        // 256 back-to-back frames, counter wraps to zero
        for (int i = 0; i < 256; i++) begin
            send_frame("b2b", 8'(i));
            if (i == 254) check("b2b_cnt255", frame_cnt, 8'hFF);
        end
        check("b2b_wrap_cnt", frame_cnt, 0);
        check("b2b_last_word", word, 8'hFF);

`ifdef BUFFER_RX_PARITY_EN
        send_frame("par_a5", 8'hA5);
        check("par_a5_cnt", frame_cnt, 1);
        send_bits(8'h3C);
        check("par_3c_busy", busy, 1);
        step(2'b11);
        check("par_bad_err", err, 1);
        check("par_bad_code", err_code, 2'b11);
        check("par_bad_valid", valid, 0);
        check("par_bad_word", word, 8'hA5);
        check("par_bad_cnt", frame_cnt, 1);
        check("par_bad_busy", busy, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
